seq_detector_param: RTL and testbench

Parametrised serial pattern detector for the lab's bit-stream front end. It accepts one qualified serial bit per clock and compares the received stream against a runtime-loadable PAT_W-bit pattern. It pulses a match flag, counts matches, and exposes the current match progress for the board display. Overlapping or non-overlapping detection is selectable at run time.

---
 rtl/seq_detector_param.sv | 97 +++++++++
 tb/tb_seq_detector_param.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern and selectable overlap.
// Produces a registered match pulse, a saturating match counter and a match-progress output.
module seq_detector_param #(
  parameter int unsigned      PAT_W     = 4,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(4'b1011),
  parameter int unsigned      CNT_W     = 8,
  parameter int unsigned      ST_W      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  output logic             z,
  output logic [CNT_W-1:0] match_cnt,
  output logic [ST_W-1:0]  state_out
);

  logic [PAT_W-1:0] pattern, pattern_d;
  logic [PAT_W-1:0] hist, hist_d, hist_n;
  logic [PAT_W-1:0] mask;
  logic [ST_W-1:0]  fill, fill_d, fill_n;
  logic [ST_W-1:0]  prog, st_d;
  logic [CNT_W-1:0] cnt_d;
  logic             hit, z_d;

  // Shifted history, saturating fill, and the longest suffix/prefix overlap
  always_comb begin
    hist_n = {hist[PAT_W-2:0], x};
    fill_n = (fill == ST_W'(PAT_W)) ? fill : fill + ST_W'(1);
    hit    = (fill_n == ST_W'(PAT_W)) && (hist_n == pattern);
    prog   = '0;
    mask   = '0;
    // Ascending scan: the last k that fits wins, so the largest valid k is kept
    for (int unsigned k = 1; k < PAT_W; k++) begin
      mask = (PAT_W'(1) << k) - PAT_W'(1);
      if ((ST_W'(k) <= fill_n) && ((hist_n & mask) == (pattern >> (PAT_W - k))))
        prog = ST_W'(k);
    end
  end

  // Next-state selection; pattern load beats a consumed bit
  always_comb begin
    pattern_d = pattern;
    hist_d    = hist;
    fill_d    = fill;
    cnt_d     = match_cnt;
    st_d      = state_out;
    z_d       = 1'b0;
    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
      cnt_d     = '0;
      st_d      = '0;
    end else if (x_valid) begin
      if (hit) begin
        z_d  = 1'b1;
        st_d = ST_W'(PAT_W);
        if (match_cnt != '1)
          cnt_d = match_cnt + CNT_W'(1);
        if (overlap) begin
          hist_d = hist_n;
          fill_d = fill_n;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = hist_n;
        fill_d = fill_n;
        st_d   = prog;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern   <= RESET_PAT;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      state_out <= '0;
      z         <= 1'b0;
    end else begin
      pattern   <= pattern_d;
      hist      <= hist_d;
      fill      <= fill_d;
      match_cnt <= cnt_d;
      state_out <= st_d;
      z         <= z_d;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_seq_detector_param;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned ST_W  = 3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             x, x_valid, overlap, pat_load;
  logic [PAT_W-1:0] pat_in;
  logic             z_a, z_b;
  logic [7:0]       cnt_a;
  logic [1:0]       cnt_b;
  logic [ST_W-1:0]  st_a, st_b;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .z(z_a), .match_cnt(cnt_a), .state_out(st_a)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .x(x), .x_valid(x_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .z(z_b), .match_cnt(cnt_b), .state_out(st_b)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: bits consumed since the last restart, oldest first
  bit               q[$];
  logic [PAT_W-1:0] m_pat;
  int               m_cnt, m_st;
  bit               m_z;

  function automatic bit tail_is_head(int k);
    for (int i = 0; i < k; i++)
      if (q[q.size() - k + i] != m_pat[PAT_W - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_pat = 4'b1011;
      m_cnt = 0;
      m_st  = 0;
      m_z   = 1'b0;
    end else begin
      m_z = 1'b0;
      if (pat_load) begin
        m_pat = pat_in;
        q.delete();
        m_cnt = 0;
        m_st  = 0;
      end else if (x_valid) begin
        q.push_back(x);
        if (q.size() > PAT_W) q.delete(0);
        if (q.size() == PAT_W && tail_is_head(PAT_W)) begin
          m_z   = 1'b1;
          m_st  = PAT_W;
          m_cnt = m_cnt + 1;
          if (!overlap) q.delete();
        end else begin
          m_st = 0;
          for (int k = 1; k < PAT_W; k++)
            if (k <= q.size() && tail_is_head(k)) m_st = k;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("z_a", int'(z_a), int'(m_z));
      check("st_a", int'(st_a), m_st);
      check("cnt_a", int'(cnt_a), (m_cnt > 255) ? 255 : m_cnt);
      check("z_b", int'(z_b), int'(m_z));
      check("st_b", int'(st_b), m_st);
      check("cnt_b", int'(cnt_b), (m_cnt > 3) ? 3 : m_cnt);
    end
  end

  task automatic step(input bit v, input bit b, input bit ov, input bit ld, input logic [3:0] p);
    @(negedge clk);
    x_valid  = v;
    x        = b;
    overlap  = ov;
    pat_load = ld;
    pat_in   = p;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_z", int'(z_a), 0);
    check("rst_st", int'(st_a), 0);
    check("rst_cnt_a", int'(cnt_a), 0);
    check("rst_cnt_b", int'(cnt_b), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int sq_st[7];
    int sq_z[7];
    bit sq_x[7];
    bit p1011[4];
    bit b;
    bit ov;
    logic [3:0] np;

    sq_x  = '{1, 0, 1, 1, 0, 1, 1};
    p1011 = '{1, 0, 1, 1};
    reset_n = 1'b0;
    x = 1'b0; x_valid = 1'b0; overlap = 1'b0; pat_load = 1'b0; pat_in = '0;

    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      step(i[0], ~i[1], 1'b0, 1'b0, 4'h0);
      check("hold_rst_z", int'(z_a), 0);
      check("hold_rst_st", int'(st_a), 0);
      check("hold_rst_cnt", int'(cnt_a), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(1'b1, p1011[i], 1'b0, 1'b0, 4'h0);
      check("post_rst_z", int'(z_a), (i == 3) ? 1 : 0);
    end
    check("post_rst_cnt", int'(cnt_a), 1);

    // Non-overlap stream
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
    sq_st = '{1, 2, 3, 4, 0, 1, 1};
    sq_z  = '{0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, sq_x[i], 1'b0, 1'b0, 4'h0);
      check("novl_st", int'(st_a), sq_st[i]);
      check("novl_z", int'(z_a), sq_z[i]);
    end
    check("novl_cnt", int'(cnt_a), 1);

    // Overlap stream
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1011);
    sq_st = '{1, 2, 3, 4, 2, 3, 4};
    sq_z  = '{0, 0, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, sq_x[i], 1'b1, 1'b0, 4'h0);
      check("ovl_st", int'(st_a), sq_st[i]);
      check("ovl_z", int'(z_a), sq_z[i]);
    end
    check("ovl_cnt", int'(cnt_a), 2);

    // Valid gaps with inverted junk on x
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, p1011[i], 1'b0, 1'b0, 4'h0);
      check("gap_st", int'(st_a), i + 1);
      check("gap_z", int'(z_a), (i == 3) ? 1 : 0);
      for (int g = 0; g < 2; g++) begin
        step(1'b0, ~p1011[i], 1'b0, 1'b0, 4'h0);
        check("gap_hold_st", int'(st_a), i + 1);
        check("gap_hold_z", int'(z_a), 0);
      end
    end

    // Pattern load mid-stream; the coincident x bit is dropped
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1011);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    check("pre_load_st", int'(st_a), 3);
    step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0110);
    check("load_st", int'(st_a), 0);
    check("load_cnt", int'(cnt_a), 0);
    check("load_z", int'(z_a), 0);
    sq_st = '{1, 2, 3, 4, 0, 0, 0};
    np = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, np[3 - i], 1'b0, 1'b0, 4'h0);
      check("newpat_st", int'(st_a), sq_st[i]);
      check("newpat_z", int'(z_a), (i == 3) ? 1 : 0);
    end
    check("newpat_cnt", int'(cnt_a), 1);

    // Periodic pattern with saturating 2-bit counter
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
      check("sat_z", int'(z_b), (i >= 3) ? 1 : 0);
      check("sat_cnt_b", int'(cnt_b), (i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2));
    end
    check("sat_cnt_a", int'(cnt_a), 5);

    // Async reset restores the default pattern
    async_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, p1011[i], 1'b0, 1'b0, 4'h0);
      check("rst_pat_z", int'(z_a), (i == 3) ? 1 : 0);
    end
    check("rst_pat_cnt", int'(cnt_a), 1);

    // Randomized traffic against the model
    ov = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) ov = ~ov;
        b = 1'(($urandom_range(0, 1)));
        np = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 3))
          0: np = 4'b1111;
          1: np = 4'b0000;
          default: ;
        endcase
        step(($urandom_range(0, 3) != 0), b, ov, ($urandom_range(0, 63) == 0), np);
      end
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
